// File: rtl/serial_subtractor_8bits.sv
// Bit-serial ripple-borrow subtractor: diff = x - y - bin, one bit per clock, LSB first.
// One full-subtractor cell and a borrow flop replace the combinational ripple chain.
module serial_subtractor_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             v
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Only WIDTH-1 bits are kept; the final bit joins them straight into diff.
  logic [WIDTH-2:0] r_r;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_xmsb;
  logic             r_ymsb;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_r_next;

  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_r_next  = {w_d, r_r};

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_xmsb  <= 1'b0;
      r_ymsb  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      v       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= x;
            r_b     <= y;
            r_br    <= bin;
            r_cnt   <= '0;
            r_xmsb  <= x[WIDTH-1];
            r_ymsb  <= y[WIDTH-1];
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_r   <= w_r_next[WIDTH-1:1];
          r_cnt <= r_cnt + CW'(1);
          // Last bit: publish the result; the next start is taken in the done cycle.
          if (r_cnt == LAST) begin
            diff    <= w_r_next;
            bout    <= w_br_next;
            v       <= (r_xmsb ^ r_ymsb) & (w_d ^ r_xmsb);
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8bits.sv
// Self-checking bench for serial_subtractor_8bits: directed table, held-start,
// mid-run reset and randomised scoreboard runs.
module tb_serial_subtractor_8bits;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] x, y;
  logic       bin;
  logic       busy, done, bout, v;
  logic [7:0] diff;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor_8bits #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .v(v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x, y;
    logic       bin;
    logic [7:0] diff;
    logic       bout, v;
  } vec_t;

  typedef struct {
    logic [7:0] x, y;
    logic       bin;
  } op_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Independent reference: integer arithmetic, returns {bout, v, diff}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
    int ud, sd;
    logic [7:0] d8;
    ud = int'(a) - int'(b) - int'(c);
    sd = int'($signed(a)) - int'($signed(b)) - int'(c);
    d8 = ud[7:0];
    return {ud < 0, (sd < -128 || sd > 127), d8};
  endfunction

  // Steps until done (bounded); optionally waves ignored starts with junk operands.
  task automatic wait_done(output int cyc, input bit noise);
    cyc = 0;
    do begin
      if (noise && ($urandom_range(0, 2) == 0)) begin
        start = 1'b1;
        x     = 8'($urandom);
        y     = 8'($urandom);
        bin   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
      if (done && busy) check("done_busy_overlap", 1, 0);
    end while (!done && cyc < 20);
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] ed, input logic eb, input logic ev);
    int cyc;
    x = a; y = b; bin = c; start = 1'b1;
    step();
    start = 1'b0;
    x = ~a; y = ~b; bin = ~c;
    check({name, "_busy_after_accept"}, busy, 1);
    wait_done(cyc, 1'b0);
    check({name, "_latency"}, cyc, 8);
    check({name, "_busy_at_done"}, busy, 0);
    check({name, "_diff"}, diff, ed);
    check({name, "_bout"}, bout, eb);
    check({name, "_v"}, v, ev);
    step();
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_diff_hold"}, diff, ed);
  endtask

  initial begin
    op_t ops[36];
    logic [9:0] m;
    int cyc, accepts, dones, gap;

    vecs[0] = '{8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0, 1'b0};
    vecs[1] = '{8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; bin = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_v", v, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].bin,
             vecs[i].diff, vecs[i].bout, vecs[i].v);

    // Start held high, operands changing every cycle: accepts at edges 0, 9, 18, 27
    // (the done cycle), completions at 8, 17, 26, 35.
    for (int c = 0; c < 36; c++) begin
      ops[c] = '{8'($urandom), 8'($urandom), 1'($urandom)};
      x = ops[c].x; y = ops[c].y; bin = ops[c].bin; start = 1'b1;
      step();
      if (c % 9 == 8) begin
        m = model(ops[c-8].x, ops[c-8].y, ops[c-8].bin);
        check($sformatf("held_done_c%0d", c), done, 1);
        check($sformatf("held_busy_c%0d", c), busy, 0);
        check($sformatf("held_res_c%0d", c), {bout, v, diff}, m);
      end else begin
        check($sformatf("held_done_c%0d", c), done, 0);
        check($sformatf("held_busy_c%0d", c), busy, 1);
      end
    end
    start = 1'b0;
    step();

    // Mid-run reset aborts the operation with no done.
    x = 8'hF0; y = 8'h0F; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    x = 8'h33; y = 8'h44;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    check("abort_v", v, 0);
    step();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op("after_abort", 8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0, 1'b0);

    // Random scoreboard with gaps 0..3 and ignored starts while busy.
    accepts = 0; dones = 0;
    for (int i = 0; i < 1000; i++) begin
      op_t o;
      o = '{8'($urandom), 8'($urandom), 1'($urandom)};
      x = o.x; y = o.y; bin = o.bin; start = 1'b1;
      step();
      if (busy) accepts++;
      wait_done(cyc, 1'b1);
      if (done) dones++;
      m = model(o.x, o.y, o.bin);
      check($sformatf("rand%0d_latency", i), cyc, 8);
      check($sformatf("rand%0d_result", i), {bout, v, diff}, m);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
    end
    check("rand_done_count", dones, accepts);
    check("rand_accept_count", accepts, 1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
